// File: rtl/dense_classifier_pkg.sv
// Shared types and sizing helpers for the dense classifier layer.
package dense_classifier_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRAIN,
        BIAS,
        ARGMAX,
        DONE
    } state_t;

    // Worst case |x*w| summed N_IN times plus a bias, with one guard bit.
    function automatic int calc_acc_w(input int x_w, input int w_w, input int n_in);
        return x_w + w_w + $clog2(n_in) + 1;
    endfunction

endpackage

// File: rtl/dense_mac_lane.sv
// Single-class accumulator: clear, multiply-accumulate of one element, bias add.
module dense_mac_lane #(
    parameter int X_W   = 38,
    parameter int W_W   = 9,
    parameter int ACC_W = 58
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    mac_en,
    input  logic                    bias_en,
    input  logic signed [X_W-1:0]   x,
    input  logic signed [W_W-1:0]   w,
    input  logic signed [W_W-1:0]   bias,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [X_W+W_W-1:0] prod;
    logic signed [ACC_W-1:0]   acc_reg;

    assign prod = (X_W+W_W)'(x) * (X_W+W_W)'(w);
    assign acc  = acc_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg <= '0;
        end else if (clear) begin
            acc_reg <= '0;
        end else if (mac_en) begin
            acc_reg <= acc_reg + ACC_W'(prod);
        end else if (bias_en) begin
            acc_reg <= acc_reg + ACC_W'(bias);
        end
    end

endmodule

// File: rtl/dense_classifier.sv
// Streaming fully-connected output layer: N_OUT parallel MAC lanes, bias add,
// then a sequential signed argmax over the class scores.
module dense_classifier
    import dense_classifier_pkg::*;
#(
    parameter  int N_IN  = 1024,
    parameter  int N_OUT = 10,
    parameter  int X_W   = 38,
    parameter  int W_W   = 9,
    localparam int ACC_W = calc_acc_w(X_W, W_W, N_IN),
    localparam int AW    = $clog2(N_IN),
    localparam int CW    = $clog2(N_OUT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   in_valid,
    input  logic [X_W-1:0]         in_data,
    output logic                   in_ready,
    output logic [AW-1:0]          w_addr,
    input  logic [N_OUT*W_W-1:0]   w_data,
    input  logic [N_OUT*W_W-1:0]   bias,
    output logic [N_OUT*ACC_W-1:0] scores,
    output logic [CW-1:0]          class_idx,
    output logic [ACC_W-1:0]       max_score,
    output logic                   busy,
    output logic                   done
);

    state_t                  state_reg, state_next;
    logic [AW-1:0]           cnt_reg;
    logic signed [X_W-1:0]   x_reg;
    logic                    x_valid_reg;
    logic [CW-1:0]           scan_reg;
    logic [CW-1:0]           class_reg;
    logic signed [ACC_W-1:0] max_reg;
    logic signed [ACC_W-1:0] lane_acc [N_OUT];

    logic accept;
    logic last_accept;
    logic start_ok;
    logic scan_last;

    assign in_ready    = (state_reg == LOAD);
    assign accept      = in_valid && in_ready;
    assign last_accept = accept && (cnt_reg == AW'(N_IN - 1));
    assign start_ok    = start && (state_reg == IDLE);
    assign scan_last   = (scan_reg == CW'(N_OUT - 1));
    assign w_addr      = cnt_reg;
    assign busy        = (state_reg != IDLE);
    assign done        = (state_reg == DONE);
    assign class_idx   = class_reg;
    assign max_score   = max_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = LOAD;
            LOAD:    if (last_accept) state_next = DRAIN;
            DRAIN:   state_next = BIAS;
            BIAS:    state_next = ARGMAX;
            ARGMAX:  if (scan_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            x_reg       <= '0;
            x_valid_reg <= 1'b0;
            scan_reg    <= '0;
            class_reg   <= '0;
            max_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            x_valid_reg <= accept;
            if (accept) begin
                x_reg   <= in_data;
                cnt_reg <= cnt_reg + 1'b1;
            end
            if (start_ok) begin
                cnt_reg   <= '0;
                scan_reg  <= '0;
                class_reg <= '0;
                max_reg   <= '0;
            end
            // Strict compare keeps the lowest index on ties; class 0 seeds the max.
            if (state_reg == ARGMAX) begin
                scan_reg <= scan_reg + 1'b1;
                if ((scan_reg == '0) || (lane_acc[scan_reg] > max_reg)) begin
                    max_reg   <= lane_acc[scan_reg];
                    class_reg <= scan_reg;
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_OUT; gi++) begin : g_lane
            dense_mac_lane #(
                .X_W   (X_W),
                .W_W   (W_W),
                .ACC_W (ACC_W)
            ) u_lane (
                .clk     (clk),
                .rst     (rst),
                .clear   (start_ok),
                .mac_en  (x_valid_reg),
                .bias_en (state_reg == BIAS),
                .x       (x_reg),
                .w       (w_data[gi*W_W +: W_W]),
                .bias    (bias[gi*W_W +: W_W]),
                .acc     (lane_acc[gi])
            );
            assign scores[gi*ACC_W +: ACC_W] = lane_acc[gi];
        end
    endgenerate

endmodule

// File: tb/tb_dense_classifier.sv
// Scoreboard bench: a small 4x3 instance for directed cases and a default-size
// instance for the no-overflow extreme.
module tb_dense_classifier;
    import dense_classifier_pkg::*;

    localparam int S_NIN  = 4;
    localparam int S_NOUT = 3;
    localparam int S_XW   = 8;
    localparam int S_WW   = 9;
    localparam int S_ACC  = calc_acc_w(S_XW, S_WW, S_NIN);
    localparam int B_NIN  = 1024;
    localparam int B_NOUT = 10;
    localparam int B_XW   = 38;
    localparam int B_WW   = 9;
    localparam int B_ACC  = calc_acc_w(B_XW, B_WW, B_NIN);

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // small instance
    logic                      s_start = 1'b0;
    logic                      s_in_valid = 1'b0;
    logic [S_XW-1:0]           s_in_data = '0;
    logic                      s_in_ready;
    logic [$clog2(S_NIN)-1:0]  s_w_addr;
    logic [S_NOUT*S_WW-1:0]    s_w_data = '0;
    logic [S_NOUT*S_WW-1:0]    s_bias = '0;
    logic [S_NOUT*S_ACC-1:0]   s_scores;
    logic [$clog2(S_NOUT)-1:0] s_class;
    logic [S_ACC-1:0]          s_max;
    logic                      s_busy;
    logic                      s_done;
    logic [S_NOUT*S_WW-1:0]    s_rom [S_NIN];

    // default-size instance
    logic                      b_start = 1'b0;
    logic                      b_in_valid = 1'b0;
    logic [B_XW-1:0]           b_in_data = '0;
    logic                      b_in_ready;
    logic [$clog2(B_NIN)-1:0]  b_w_addr;
    logic [B_NOUT*B_WW-1:0]    b_w_data = '0;
    logic [B_NOUT*B_WW-1:0]    b_bias = '0;
    logic [B_NOUT*B_ACC-1:0]   b_scores;
    logic [$clog2(B_NOUT)-1:0] b_class;
    logic [B_ACC-1:0]          b_max;
    logic                      b_busy;
    logic                      b_done;

    always @(posedge clk) s_w_data <= s_rom[s_w_addr];
    // every row of the extreme case is -256 in all classes
    always @(posedge clk) b_w_data <= {B_NOUT{9'h100}};

    dense_classifier #(.N_IN(S_NIN), .N_OUT(S_NOUT), .X_W(S_XW), .W_W(S_WW)) u_small (
        .clk(clk), .rst(rst), .start(s_start), .in_valid(s_in_valid), .in_data(s_in_data),
        .in_ready(s_in_ready), .w_addr(s_w_addr), .w_data(s_w_data), .bias(s_bias),
        .scores(s_scores), .class_idx(s_class), .max_score(s_max), .busy(s_busy), .done(s_done)
    );

    dense_classifier #(.N_IN(B_NIN), .N_OUT(B_NOUT), .X_W(B_XW), .W_W(B_WW)) u_big (
        .clk(clk), .rst(rst), .start(b_start), .in_valid(b_in_valid), .in_data(b_in_data),
        .in_ready(b_in_ready), .w_addr(b_w_addr), .w_data(b_w_data), .bias(b_bias),
        .scores(b_scores), .class_idx(b_class), .max_score(b_max), .busy(b_busy), .done(b_done)
    );

    typedef struct {
        logic [S_NOUT*S_ACC-1:0] scores;
        int                      cls;
        logic [S_ACC-1:0]        mx;
        int                      done_cyc;
    } s_exp_t;

    typedef struct {
        logic [B_NOUT*B_ACC-1:0] scores;
        int                      cls;
        logic [B_ACC-1:0]        mx;
        int                      done_cyc;
    } b_exp_t;

    s_exp_t s_q[$];
    b_exp_t b_q[$];
    s_exp_t s_e;
    b_exp_t b_e;

    int sx[S_NIN];
    int sgap[S_NIN];
    int sbias[S_NOUT];
    int s_es[S_NOUT];
    int s_ecls;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
        end
    endtask

    function automatic logic [S_NOUT*S_WW-1:0] pack3(input int a, input int b, input int c);
        return {S_WW'(c), S_WW'(b), S_WW'(a)};
    endfunction

    // monitors: one pop per done pulse; a done with nothing expected is an error
    always @(negedge clk) begin
        if (s_done) begin
            if (s_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL s_spurious_done cyc=%0d actual=done required=no_done", cyc);
            end else begin
                s_e = s_q.pop_front();
                for (int k = 0; k < S_NOUT; k++)
                    chk($sformatf("s_score%0d", k), $signed(s_scores[k*S_ACC +: S_ACC]),
                        $signed(s_e.scores[k*S_ACC +: S_ACC]));
                chk("s_class_idx", s_class, s_e.cls);
                chk("s_max_score", $signed(s_max), $signed(s_e.mx));
                chk("s_done_cycle", cyc, s_e.done_cyc);
                $display("txn small cyc=%0d class=%0d max=%0d", cyc, s_class, $signed(s_max));
            end
        end
    end

    always @(negedge clk) begin
        if (b_done) begin
            if (b_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL b_spurious_done cyc=%0d actual=done required=no_done", cyc);
            end else begin
                b_e = b_q.pop_front();
                for (int k = 0; k < B_NOUT; k++)
                    chk($sformatf("b_score%0d", k), $signed(b_scores[k*B_ACC +: B_ACC]),
                        $signed(b_e.scores[k*B_ACC +: B_ACC]));
                chk("b_class_idx", b_class, b_e.cls);
                chk("b_max_score", $signed(b_max), $signed(b_e.mx));
                chk("b_done_cycle", cyc, b_e.done_cyc);
                $display("txn big cyc=%0d class=%0d max=%0d", cyc, b_class, $signed(b_max));
            end
        end
    end

    task automatic check_s_zero(input string name);
        chk({name, "_in_ready"}, s_in_ready, 0);
        chk({name, "_busy"}, s_busy, 0);
        chk({name, "_done"}, s_done, 0);
        chk({name, "_w_addr"}, s_w_addr, 0);
        chk({name, "_scores"}, s_scores, 0);
        chk({name, "_class_idx"}, s_class, 0);
        chk({name, "_max_score"}, s_max, 0);
    endtask

    task automatic wait_s_idle(input string name, input int budget);
        int n = 0;
        while ((s_q.size() != 0 || s_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_completed"}, (n < budget) ? 1 : 0, 1);
    endtask

    task automatic run_small(input string name, input bit protocol);
        s_exp_t e;
        int     cyc_s;
        int     stalls = 0;
        for (int i = 0; i < S_NIN; i++) stalls += sgap[i];
        s_bias = pack3(sbias[0], sbias[1], sbias[2]);
        @(negedge clk);
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        cyc_s = cyc;
        for (int k = 0; k < S_NOUT; k++) e.scores[k*S_ACC +: S_ACC] = S_ACC'(s_es[k]);
        e.cls = s_ecls;
        e.mx = S_ACC'(s_es[s_ecls]);
        // last accept at S+N_IN+stalls; done is sampled by edge E+N_OUT+3
        e.done_cyc = cyc_s + S_NIN + stalls + S_NOUT + 2;
        s_q.push_back(e);
        for (int i = 0; i < S_NIN; i++) begin
            for (int g = 0; g < sgap[i]; g++) begin
                s_in_valid = 1'b0;
                @(negedge clk);
                chk({name, "_w_addr_stall"}, s_w_addr, i);
            end
            chk({name, "_in_ready"}, s_in_ready, 1);
            s_in_valid = 1'b1;
            s_in_data = S_XW'(sx[i]);
            if (protocol && i == 2) s_start = 1'b1;
            @(negedge clk);
            s_start = 1'b0;
            if (protocol && i == 2) chk({name, "_w_addr_after_start"}, s_w_addr, 3);
        end
        s_in_valid = 1'b0;
        if (protocol) begin
            s_in_valid = 1'b1;
            s_start = 1'b1;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                chk({name, "_in_ready_busy"}, s_in_ready, 0);
                chk({name, "_w_addr_busy"}, s_w_addr, 0);  // 4 accepts wrap a 2-bit counter
            end
            s_in_valid = 1'b0;
            s_start = 1'b0;
        end
        wait_s_idle(name, 40);
    endtask

    initial begin
        b_exp_t be;
        int     cyc_b;
        longint big_score;

        s_rom[0] = pack3(1, 0, -1);
        s_rom[1] = pack3(1, 1, 0);
        s_rom[2] = pack3(1, 0, 1);
        s_rom[3] = pack3(1, 2, -1);

        repeat (3) @(negedge clk);
        check_s_zero("reset");
        chk("b_reset_busy", b_busy, 0);
        chk("b_reset_scores", (b_scores == '0) ? 1 : 0, 1);
        rst = 1'b0;

        // basic dot product: class1 = 2*1 + 4*2 + 5 = 15
        sx = '{1, 2, 3, 4};  sgap = '{0, 0, 0, 0};  sbias = '{0, 5, -2};
        s_es = '{10, 15, -4};  s_ecls = 1;
        run_small("basic", 1'b0);

        // tie among all-negative scores resolves to the lower index
        sx = '{0, 0, 0, 0};  sbias = '{-3, -1, -1};
        s_es = '{-3, -1, -1};  s_ecls = 1;
        run_small("tie", 1'b0);

        // stalled stream: three idle cycles in total
        sx = '{1, 2, 3, 4};  sgap = '{0, 2, 0, 1};  sbias = '{0, 5, -2};
        s_es = '{10, 15, -4};  s_ecls = 1;
        run_small("stall", 1'b0);

        // reset while idle clears held results
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_s_zero("idle_reset");
        rst = 1'b0;

        // reset for two cycles mid-LOAD, then a clean run
        @(negedge clk);
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        s_in_valid = 1'b1;
        s_in_data = 8'd7;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_s_zero("load_reset");
        s_in_valid = 1'b0;
        rst = 1'b0;
        repeat (20) @(negedge clk);
        sgap = '{0, 0, 0, 0};
        run_small("after_reset", 1'b0);

        // start and in_valid while busy are ignored
        run_small("protocol", 1'b1);

        // extremes at default size: 1024 * (-2^37 * -256) - 256
        big_score = (longint'(1) <<< 55) - 256;
        b_bias = {B_NOUT{9'h100}};
        @(negedge clk);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        cyc_b = cyc;
        for (int k = 0; k < B_NOUT; k++) be.scores[k*B_ACC +: B_ACC] = B_ACC'(big_score);
        be.cls = 0;
        be.mx = B_ACC'(big_score);
        be.done_cyc = cyc_b + B_NIN + B_NOUT + 2;
        b_q.push_back(be);
        chk("b_in_ready", b_in_ready, 1);
        b_in_valid = 1'b1;
        b_in_data = {1'b1, {(B_XW-1){1'b0}}};
        repeat (B_NIN) @(negedge clk);
        b_in_valid = 1'b0;
        begin
            int n = 0;
            while ((b_q.size() != 0 || b_busy) && n < 60) begin
                @(negedge clk);
                n++;
            end
            chk("extreme_completed", (n < 60) ? 1 : 0, 1);
        end

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
